// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: steps through the fetch/execute T-states and
// decodes the current state and IR into every datapath strobe and the ALU opcode.
module control_sequencer #(
  parameter logic [4:0] PC_INC_OP = 5'b11111
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        Pen,
  output logic        Pout,
  output logic        MARen,
  output logic        MDRen,
  output logic        MDROut,
  output logic        Read,
  output logic        IRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIen,
  output logic        LOen,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        illegal
);

  localparam logic [3:0] StReset = 4'd0;
  localparam logic [3:0] StT0    = 4'd1;
  localparam logic [3:0] StT1    = 4'd2;
  localparam logic [3:0] StT2    = 4'd3;
  localparam logic [3:0] StT3    = 4'd4;
  localparam logic [3:0] StT4    = 4'd5;
  localparam logic [3:0] StT5    = 4'd6;
  localparam logic [3:0] StT6    = 4'd7;
  localparam logic [3:0] StHalt  = 4'd8;

  localparam logic [4:0] OpAluLast = 5'b01000;
  localparam logic [4:0] OpMul     = 5'b01111;
  localparam logic [4:0] OpDiv     = 5'b10000;
  localparam logic [4:0] OpNop     = 5'b11010;
  localparam logic [4:0] OpHalt    = 5'b11011;

  logic [3:0] state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_nop, is_halt;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign is_alu    = (opcode <= OpAluLast);
  assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
  assign is_nop    = (opcode == OpNop);
  assign is_halt   = (opcode == OpHalt);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StReset;
    case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = mem_ready ? StT2 : StT1;
      StT2:    state_d = StT3;
      StT3: begin
        if (is_alu || is_muldiv) begin
          state_d = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT0;
        end
      end
      StT4:    state_d = (is_alu || is_muldiv) ? StT5 : StT0;
      StT5:    state_d = is_muldiv ? StT6 : StT0;
      StT6:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    Rin         = '0;
    Rout        = '0;
    Pen         = 1'b0;
    Pout        = 1'b0;
    MARen       = 1'b0;
    MDRen       = 1'b0;
    MDROut      = 1'b0;
    Read        = 1'b0;
    IRen        = 1'b0;
    Yen         = 1'b0;
    ZLOen       = 1'b0;
    ZHIen       = 1'b0;
    ZLOout      = 1'b0;
    ZHIout      = 1'b0;
    HIen        = 1'b0;
    LOen        = 1'b0;
    alu_control = 5'b00000;
    run         = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StT0: begin
        run         = 1'b1;
        Pout        = 1'b1;
        MARen       = 1'b1;
        ZLOen       = 1'b1;
        alu_control = PC_INC_OP;
      end
      // Held through memory stalls; reloading PC from an unchanged ZLO is harmless.
      StT1: begin
        run    = 1'b1;
        ZLOout = 1'b1;
        Pen    = 1'b1;
        Read   = 1'b1;
        MDRen  = 1'b1;
      end
      StT2: begin
        run    = 1'b1;
        MDROut = 1'b1;
        IRen   = 1'b1;
      end
      StT3: begin
        run = 1'b1;
        if (is_alu) begin
          Rout = 16'h0001 << rb;
          Yen  = 1'b1;
        end else if (is_muldiv) begin
          Rout = 16'h0001 << ra;
          Yen  = 1'b1;
        end else if (!is_nop && !is_halt) begin
          illegal = 1'b1;
        end
      end
      StT4: begin
        run = 1'b1;
        if (is_alu) begin
          Rout        = 16'h0001 << rc;
          ZLOen       = 1'b1;
          alu_control = opcode + 5'd1;
        end else if (is_muldiv) begin
          Rout        = 16'h0001 << rb;
          ZLOen       = 1'b1;
          ZHIen       = 1'b1;
          alu_control = opcode + 5'd1;
        end
      end
      StT5: begin
        run = 1'b1;
        if (is_alu) begin
          ZLOout = 1'b1;
          Rin    = 16'h0001 << ra;
        end else if (is_muldiv) begin
          ZLOout = 1'b1;
          LOen   = 1'b1;
        end
      end
      StT6: begin
        run    = 1'b1;
        ZHIout = 1'b1;
        HIen   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks reset, ALU, MUL/DIV, stall, NOP,
// illegal, halt and mid-instruction reset, checking every output each step.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic        Pen, Pout, MARen, MDRen, MDROut, Read, IRen, Yen;
  logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen;
  logic [4:0]  alu_control;
  logic        run, illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0_cyc = 0;
  bit done   = 1'b0;

  // Strobe bits: Pen Pout MARen MDRen MDROut Read IRen Yen ZLOen ZHIen ZLOout ZHIout HIen LOen
  localparam logic [13:0] SPen    = 14'h2000;
  localparam logic [13:0] SPout   = 14'h1000;
  localparam logic [13:0] SMARen  = 14'h0800;
  localparam logic [13:0] SMDRen  = 14'h0400;
  localparam logic [13:0] SMDROut = 14'h0200;
  localparam logic [13:0] SRead   = 14'h0100;
  localparam logic [13:0] SIRen   = 14'h0080;
  localparam logic [13:0] SYen    = 14'h0040;
  localparam logic [13:0] SZLOen  = 14'h0020;
  localparam logic [13:0] SZHIen  = 14'h0010;
  localparam logic [13:0] SZLOout = 14'h0008;
  localparam logic [13:0] SZHIout = 14'h0004;
  localparam logic [13:0] SHIen   = 14'h0002;
  localparam logic [13:0] SLOen   = 14'h0001;

  localparam logic [31:0] IrSra  = 32'h2891_8000;
  localparam logic [31:0] IrMul  = 32'h7918_0000;
  localparam logic [31:0] IrNop  = 32'hD000_0000;
  localparam logic [31:0] IrHalt = 32'hD800_0000;
  localparam logic [31:0] IrIll  = 32'hF800_0000;

  logic [13:0] strb;
  assign strb = {Pen, Pout, MARen, MDRen, MDROut, Read, IRen, Yen,
                 ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen};

  control_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .Rin        (Rin),
    .Rout       (Rout),
    .Pen        (Pen),
    .Pout       (Pout),
    .MARen      (MARen),
    .MDRen      (MDRen),
    .MDROut     (MDROut),
    .Read       (Read),
    .IRen       (IRen),
    .Yen        (Yen),
    .ZLOen      (ZLOen),
    .ZHIen      (ZHIen),
    .ZLOout     (ZLOout),
    .ZHIout     (ZHIout),
    .HIen       (HIen),
    .LOen       (LOen),
    .alu_control(alu_control),
    .run        (run),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e_rin,
                            input logic [15:0] e_rout, input logic [13:0] e_strb,
                            input logic [4:0] e_alu, input logic e_run, input logic e_ill);
    check({tag, ".Rin"}, 32'(Rin), 32'(e_rin));
    check({tag, ".Rout"}, 32'(Rout), 32'(e_rout));
    check({tag, ".strobes"}, 32'(strb), 32'(e_strb));
    check({tag, ".alu"}, 32'(alu_control), 32'(e_alu));
    check({tag, ".run"}, 32'(run), 32'(e_run));
    check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_t0(input string tag);
    check_outs(tag, 16'h0, 16'h0, SPout | SMARen | SZLOen, 5'b11111, 1'b1, 1'b0);
  endtask

  // Called while in a checked T0; returns in T3 with ir loaded.
  task automatic fetch(input string tag, input logic [31:0] instr, input int stalls);
    mem_ready = (stalls == 0);
    tick();
    check_outs({tag, ".T1"}, 16'h0, 16'h0, SZLOout | SPen | SRead | SMDRen, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < stalls; i++) begin
      tick();
      check_outs({tag, ".T1stall"}, 16'h0, 16'h0, SZLOout | SPen | SRead | SMDRen, 5'd0,
                 1'b1, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    check_outs({tag, ".T2"}, 16'h0, 16'h0, SMDROut | SIRen, 5'd0, 1'b1, 1'b0);
    ir = instr;
    tick();
  endtask

  task automatic expect_t0(input string tag, input int latency);
    tick();
    check_t0({tag, ".T0"});
    check({tag, ".latency"}, 32'(cyc - t0_cyc), 32'(latency));
    t0_cyc = cyc;
  endtask

  // Never more than one source driving the shared bus.
  always @(negedge clk) begin
    if (!done) begin
      checks++;
      assert ((32'(Pout) + 32'(MDROut) + 32'(ZLOout) + 32'(ZHIout) + $countones(Rout)) <= 1)
      else begin
        errors++;
        $error("FAIL bus_contention: observed Pout=%0b MDROut=%0b ZLOout=%0b ZHIout=%0b Rout=%0h expected at most one source",
               Pout, MDROut, ZLOout, ZHIout, Rout);
      end
    end
  end

  initial begin
    clr       = 1'b1;
    ir        = 32'h0;
    mem_ready = 1'b1;

    tick();
    check_outs("reset1", 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
    tick();
    check_outs("reset2", 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    check_t0("reset.T0");
    t0_cyc = cyc;

    fetch("sra", IrSra, 0);
    check_outs("sra.T3", 16'h0, 16'h0004, SYen, 5'd0, 1'b1, 1'b0);
    tick();
    check_outs("sra.T4", 16'h0, 16'h0008, SZLOen, 5'b00110, 1'b1, 1'b0);
    tick();
    check_outs("sra.T5", 16'h0002, 16'h0, SZLOout, 5'd0, 1'b1, 1'b0);
    expect_t0("sra", 6);

    fetch("mul", IrMul, 0);
    check_outs("mul.T3", 16'h0, 16'h0004, SYen, 5'd0, 1'b1, 1'b0);
    tick();
    check_outs("mul.T4", 16'h0, 16'h0008, SZLOen | SZHIen, 5'b10000, 1'b1, 1'b0);
    tick();
    check_outs("mul.T5", 16'h0, 16'h0, SZLOout | SLOen, 5'd0, 1'b1, 1'b0);
    tick();
    check_outs("mul.T6", 16'h0, 16'h0, SZHIout | SHIen, 5'd0, 1'b1, 1'b0);
    expect_t0("mul", 7);

    fetch("nop_stall", IrNop, 3);
    check_outs("nop.T3", 16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b0);
    expect_t0("nop_stall", 7);

    fetch("ill", IrIll, 0);
    check_outs("ill.T3", 16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b1);
    expect_t0("ill", 4);

    fetch("sra_rst", IrSra, 0);
    check_outs("sra_rst.T3", 16'h0, 16'h0004, SYen, 5'd0, 1'b1, 1'b0);
    tick();
    check_outs("sra_rst.T4", 16'h0, 16'h0008, SZLOen, 5'b00110, 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    check_outs("sra_rst.reset", 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    check_t0("sra_rst.T0");
    t0_cyc = cyc;

    fetch("halt", IrHalt, 0);
    check_outs("halt.T3", 16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      tick();
      check_outs("halt.hold", 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
    end
    mem_ready = 1'b1;
    clr = 1'b1;
    tick();
    check_outs("halt.reset", 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    check_t0("halt.T0");

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
